// File: rtl/dcache_mshr_if.sv
// Memory-side bus between the MSHR sequencer (master) and the memory model/controller (slave).
// One request in flight at a time; read data returns on a single-cycle rvalid pulse.
interface dcache_mshr_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/dcache_mshr.sv
// Two-entry miss status holding registers with a one-transaction-at-a-time memory sequencer.
// Optional MSHR_STATS_EN adds load/evict/full-cycle counters; otherwise the stat ports read 0.
module dcache_mshr #(
    parameter int          NUM_ENTRIES = 2,
    parameter logic [31:0] INV_ADDR    = 32'hFFFF_FFFF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_valid,
    input  logic          evict_valid,
    input  logic [31:0]   addr_load,
    input  logic [31:0]   addr_evict,
    input  logic [31:0]   evict_data,
    input  logic [4:0]    mshr_regD_in,
    input  logic          load_way_in,
    output logic [31:0]   addr1,
    output logic [31:0]   addr2,
    output logic [31:0]   addr3,
    output logic [31:0]   addr4,
    output logic          mshr_full,
    output logic          mshr_done_pulse,
    output logic [31:0]   mshr_addr_out,
    output logic [31:0]   mshr_data_out,
    output logic [4:0]    mshr_regD_out,
    output logic          load_way_out,
    output logic [31:0]   stat_loads,
    output logic [31:0]   stat_evicts,
    output logic [31:0]   stat_full_cycles,
    dcache_mshr_if.master mem
);

    typedef enum logic [2:0] {
        E_FREE, E_EVICT_PEND, E_LOAD_PEND, E_LOAD_ISSUED, E_DONE
    } ent_state_t;

    typedef enum logic [1:0] {
        M_IDLE, M_WR_REQ, M_RD_REQ, M_RD_WAIT
    } mem_state_t;

    ent_state_t  r_ent_state    [NUM_ENTRIES];
    logic        r_ent_has_load [NUM_ENTRIES];
    logic [31:0] r_ent_laddr    [NUM_ENTRIES];
    logic [31:0] r_ent_eaddr    [NUM_ENTRIES];
    logic [31:0] r_ent_edata    [NUM_ENTRIES];
    logic [4:0]  r_ent_regd     [NUM_ENTRIES];
    logic        r_ent_way      [NUM_ENTRIES];
    logic        r_older;
    logic        r_full;

    mem_state_t  r_mstate, w_mstate_next;
    logic        r_cur, w_cur_next;
    logic        r_mem_req, w_mem_req_next;
    logic        r_mem_we, w_mem_we_next;
    logic [31:0] r_mem_addr, w_mem_addr_next;
    logic [31:0] r_mem_wdata, w_mem_wdata_next;

    logic        r_done_pulse;
    logic [31:0] r_done_addr;
    logic [31:0] r_done_data;
    logic [4:0]  r_done_regd;
    logic        r_done_way;

    logic [NUM_ENTRIES-1:0] w_free;
    logic [NUM_ENTRIES-1:0] w_pend;
    logic [31:0] w_trk_load  [NUM_ENTRIES];
    logic [31:0] w_trk_evict [NUM_ENTRIES];
    logic        w_alloc_ok;
    logic        w_alloc_idx;
    logic        w_pick_idx;
    logic        w_wr_accept;
    logic        w_rd_accept;
    logic        w_rd_fill;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_ent
            assign w_free[gi]      = (r_ent_state[gi] == E_FREE);
            assign w_pend[gi]      = (r_ent_state[gi] == E_EVICT_PEND) || (r_ent_state[gi] == E_LOAD_PEND);
            assign w_trk_load[gi]  = (!w_free[gi] && r_ent_has_load[gi]) ? r_ent_laddr[gi] : INV_ADDR;
            assign w_trk_evict[gi] = (r_ent_state[gi] == E_EVICT_PEND) ? r_ent_eaddr[gi] : INV_ADDR;
        end
    endgenerate

    assign addr1 = w_trk_load[0];
    assign addr2 = w_trk_evict[0];
    assign addr3 = w_trk_load[1];
    assign addr4 = w_trk_evict[1];

    // Allocation looks only at pre-edge state, so an entry freeing this edge is not reused until next cycle.
    assign w_alloc_idx = w_free[0] ? 1'b0 : 1'b1;
    assign w_alloc_ok  = (load_valid | evict_valid) & (|w_free) & ~r_full;
    assign w_pick_idx  = w_pend[r_older] ? r_older : ~r_older;

    always_comb begin
        w_mstate_next    = r_mstate;
        w_cur_next       = r_cur;
        w_mem_req_next   = r_mem_req;
        w_mem_we_next    = r_mem_we;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_wr_accept      = 1'b0;
        w_rd_accept      = 1'b0;
        w_rd_fill        = 1'b0;
        case (r_mstate)
            M_IDLE: begin
                if (|w_pend) begin
                    w_cur_next     = w_pick_idx;
                    w_mem_req_next = 1'b1;
                    if (r_ent_state[w_pick_idx] == E_EVICT_PEND) begin
                        w_mstate_next    = M_WR_REQ;
                        w_mem_we_next    = 1'b1;
                        w_mem_addr_next  = r_ent_eaddr[w_pick_idx];
                        w_mem_wdata_next = r_ent_edata[w_pick_idx];
                    end else begin
                        w_mstate_next    = M_RD_REQ;
                        w_mem_we_next    = 1'b0;
                        w_mem_addr_next  = r_ent_laddr[w_pick_idx];
                        w_mem_wdata_next = 32'd0;
                    end
                end
            end
            M_WR_REQ, M_RD_REQ: begin
                if (mem.mem_ready) begin
                    w_wr_accept      = (r_mstate == M_WR_REQ);
                    w_rd_accept      = (r_mstate == M_RD_REQ);
                    w_mstate_next    = (r_mstate == M_WR_REQ) ? M_IDLE : M_RD_WAIT;
                    w_mem_req_next   = 1'b0;
                    w_mem_we_next    = 1'b0;
                    w_mem_addr_next  = 32'd0;
                    w_mem_wdata_next = 32'd0;
                end
            end
            M_RD_WAIT: begin
                if (mem.mem_rvalid) begin
                    w_rd_fill     = 1'b1;
                    w_mstate_next = M_IDLE;
                end
            end
            default: w_mstate_next = M_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mstate     <= M_IDLE;
            r_cur        <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_done_pulse <= 1'b0;
            r_done_addr  <= 32'd0;
            r_done_data  <= 32'd0;
            r_done_regd  <= 5'd0;
            r_done_way   <= 1'b0;
        end else begin
            r_mstate     <= w_mstate_next;
            r_cur        <= w_cur_next;
            r_mem_req    <= w_mem_req_next;
            r_mem_we     <= w_mem_we_next;
            r_mem_addr   <= w_mem_addr_next;
            r_mem_wdata  <= w_mem_wdata_next;
            r_done_pulse <= w_rd_fill;
            r_done_addr  <= w_rd_fill ? r_ent_laddr[r_cur] : 32'd0;
            r_done_data  <= w_rd_fill ? mem.mem_rdata : 32'd0;
            r_done_regd  <= w_rd_fill ? r_ent_regd[r_cur] : 5'd0;
            r_done_way   <= w_rd_fill ? r_ent_way[r_cur] : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_older <= 1'b0;
            r_full  <= 1'b0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_ent_state[i]    <= E_FREE;
                r_ent_has_load[i] <= 1'b0;
                r_ent_laddr[i]    <= 32'd0;
                r_ent_eaddr[i]    <= 32'd0;
                r_ent_edata[i]    <= 32'd0;
                r_ent_regd[i]     <= 5'd0;
                r_ent_way[i]      <= 1'b0;
            end
        end else begin
            r_full <= ~(|w_free);
            if (w_alloc_ok)
                r_older <= ~w_alloc_idx;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (w_alloc_ok && (w_alloc_idx == 1'(i))) begin
                    r_ent_state[i]    <= evict_valid ? E_EVICT_PEND : E_LOAD_PEND;
                    r_ent_has_load[i] <= load_valid;
                    r_ent_laddr[i]    <= addr_load;
                    r_ent_eaddr[i]    <= addr_evict;
                    r_ent_edata[i]    <= evict_data;
                    r_ent_regd[i]     <= mshr_regD_in;
                    r_ent_way[i]      <= load_way_in;
                end else if (w_wr_accept && (r_cur == 1'(i))) begin
                    r_ent_state[i] <= r_ent_has_load[i] ? E_LOAD_PEND : E_FREE;
                end else if (w_rd_accept && (r_cur == 1'(i))) begin
                    r_ent_state[i] <= E_LOAD_ISSUED;
                end else if (w_rd_fill && (r_cur == 1'(i))) begin
                    r_ent_state[i] <= E_DONE;
                end else if (r_ent_state[i] == E_DONE) begin
                    r_ent_state[i] <= E_FREE;
                end
            end
        end
    end

`ifdef MSHR_STATS_EN
    logic [31:0] r_stat_loads, r_stat_evicts, r_stat_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_loads  <= 32'd0;
            r_stat_evicts <= 32'd0;
            r_stat_full   <= 32'd0;
        end else begin
            if (w_alloc_ok && load_valid)
                r_stat_loads <= r_stat_loads + 32'd1;
            if (w_alloc_ok && evict_valid)
                r_stat_evicts <= r_stat_evicts + 32'd1;
            if (r_full)
                r_stat_full <= r_stat_full + 32'd1;
        end
    end

    assign stat_loads       = r_stat_loads;
    assign stat_evicts      = r_stat_evicts;
    assign stat_full_cycles = r_stat_full;
`else
    assign stat_loads       = 32'd0;
    assign stat_evicts      = 32'd0;
    assign stat_full_cycles = 32'd0;
`endif

    assign mshr_full       = r_full;
    assign mshr_done_pulse = r_done_pulse;
    assign mshr_addr_out   = r_done_addr;
    assign mshr_data_out   = r_done_data;
    assign mshr_regD_out   = r_done_regd;
    assign load_way_out    = r_done_way;
    assign mem.mem_req     = r_mem_req;
    assign mem.mem_we      = r_mem_we;
    assign mem.mem_addr    = r_mem_addr;
    assign mem.mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_dcache_mshr.sv
// Randomized bench for dcache_mshr: an age-ordered entry list plus a single outstanding
// memory transaction predicts every output each cycle.
module tb_dcache_mshr;
    localparam logic [31:0] INV = 32'hFFFF_FFFF;
    localparam int PH_IDLE = 0, PH_REQ = 1, PH_WAIT = 2;
    localparam int LD_PEND = 0, LD_ISS = 1, LD_DONE = 2;
    localparam int NCYC = 4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid, evict_valid;
    logic [31:0] addr_load, addr_evict, evict_data;
    logic [4:0]  regd_in;
    logic        way_in;
    logic [31:0] addr1, addr2, addr3, addr4;
    logic        full, done;
    logic [31:0] done_addr, done_data;
    logic [4:0]  done_regd;
    logic        done_way;
    logic [31:0] st_loads, st_evicts, st_full;

    dcache_mshr_if mem_bus();

    dcache_mshr dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .evict_valid(evict_valid),
        .addr_load(addr_load), .addr_evict(addr_evict), .evict_data(evict_data),
        .mshr_regD_in(regd_in), .load_way_in(way_in),
        .addr1(addr1), .addr2(addr2), .addr3(addr3), .addr4(addr4),
        .mshr_full(full), .mshr_done_pulse(done),
        .mshr_addr_out(done_addr), .mshr_data_out(done_data),
        .mshr_regD_out(done_regd), .load_way_out(done_way),
        .stat_loads(st_loads), .stat_evicts(st_evicts), .stat_full_cycles(st_full),
        .mem(mem_bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    typedef struct {
        bit          busy;
        bit          has_load;
        bit          ev_pend;
        int          ld_st;
        logic [31:0] la;
        logic [31:0] ea;
        logic [31:0] ed;
        logic [4:0]  rd;
        bit          way;
    } ent_t;

    ent_t        ent [2];
    int          age_q[$];
    int          phase, cur;
    bit          tx_we;
    logic [31:0] tx_addr, tx_wdata;
    bit          m_full;
    bit          p_valid;
    logic [31:0] p_addr, p_data;
    logic [4:0]  p_rd;
    bit          p_way;
    int          c_loads, c_evicts, c_full;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ent[i].busy = 0; ent[i].has_load = 0; ent[i].ev_pend = 0; ent[i].ld_st = LD_PEND;
        end
        age_q.delete();
        phase = PH_IDLE; cur = 0; tx_we = 0; tx_addr = 0; tx_wdata = 0;
        m_full = 0; p_valid = 0; p_addr = 0; p_data = 0; p_rd = 0; p_way = 0;
        c_loads = 0; c_evicts = 0; c_full = 0;
    endtask

    task automatic retire(input int idx);
        ent[idx].busy = 0;
        for (int k = 0; k < age_q.size(); k++)
            if (age_q[k] == idx) begin
                age_q.delete(k);
                break;
            end
    endtask

    // Advance the model across one rising edge using the inputs held during the cycle before it.
    task automatic model_step();
        int a_idx;
        bit a_ok, full_n;
        bit free_now [2];
        if (rst) begin
            model_reset();
            return;
        end
        a_idx = -1;
        for (int i = 0; i < 2; i++)
            if (!ent[i].busy && a_idx < 0) a_idx = i;
        a_ok   = (load_valid || evict_valid) && (a_idx >= 0) && !m_full;
        full_n = ent[0].busy && ent[1].busy;
        if (m_full) c_full++;
        for (int i = 0; i < 2; i++)
            free_now[i] = ent[i].busy && ent[i].has_load && ent[i].ld_st == LD_DONE;
        p_valid = 0; p_addr = 0; p_data = 0; p_rd = 0; p_way = 0;
        case (phase)
            PH_REQ: if (mem_bus.mem_ready) begin
                $display("tx accept %s addr=%h wdata=%h entry=%0d", tx_we ? "WR" : "RD", tx_addr, tx_wdata, cur);
                if (tx_we) begin
                    ent[cur].ev_pend = 0;
                    if (!ent[cur].has_load) retire(cur);
                    phase = PH_IDLE;
                end else begin
                    ent[cur].ld_st = LD_ISS;
                    phase = PH_WAIT;
                end
            end
            PH_WAIT: if (mem_bus.mem_rvalid) begin
                p_valid = 1; p_addr = ent[cur].la; p_data = mem_bus.mem_rdata;
                p_rd = ent[cur].rd; p_way = ent[cur].way;
                ent[cur].ld_st = LD_DONE;
                phase = PH_IDLE;
                $display("tx fill addr=%h data=%h regD=%0d way=%0d", p_addr, p_data, p_rd, p_way);
            end
            default: begin
                foreach (age_q[k]) begin
                    int e;
                    e = age_q[k];
                    if (ent[e].ev_pend || (ent[e].has_load && ent[e].ld_st == LD_PEND)) begin
                        cur = e;
                        phase = PH_REQ;
                        tx_we = ent[e].ev_pend;
                        tx_addr = tx_we ? ent[e].ea : ent[e].la;
                        tx_wdata = ent[e].ed;
                        break;
                    end
                end
            end
        endcase
        for (int i = 0; i < 2; i++)
            if (free_now[i]) retire(i);
        if (a_ok) begin
            ent[a_idx].busy = 1; ent[a_idx].has_load = load_valid; ent[a_idx].ev_pend = evict_valid;
            ent[a_idx].ld_st = LD_PEND; ent[a_idx].la = addr_load; ent[a_idx].ea = addr_evict;
            ent[a_idx].ed = evict_data; ent[a_idx].rd = regd_in; ent[a_idx].way = way_in;
            age_q.push_back(a_idx);
            if (load_valid) c_loads++;
            if (evict_valid) c_evicts++;
        end
        m_full = full_n;
    endtask

    task automatic check_outputs();
        chk("addr1", addr1, (ent[0].busy && ent[0].has_load) ? ent[0].la : INV);
        chk("addr2", addr2, (ent[0].busy && ent[0].ev_pend) ? ent[0].ea : INV);
        chk("addr3", addr3, (ent[1].busy && ent[1].has_load) ? ent[1].la : INV);
        chk("addr4", addr4, (ent[1].busy && ent[1].ev_pend) ? ent[1].ea : INV);
        chk("full", full, m_full);
        chk("done_pulse", done, p_valid);
        chk("done_addr", done_addr, p_addr);
        chk("done_data", done_data, p_data);
        chk("done_regD", done_regd, p_rd);
        chk("done_way", done_way, p_way);
        chk("mem_req", mem_bus.mem_req, phase == PH_REQ);
        if (phase == PH_REQ) begin
            chk("mem_we", mem_bus.mem_we, tx_we);
            chk("mem_addr", mem_bus.mem_addr, tx_addr);
            if (tx_we) chk("mem_wdata", mem_bus.mem_wdata, tx_wdata);
        end
`ifdef MSHR_STATS_EN
        chk("stat_loads", st_loads, c_loads);
        chk("stat_evicts", st_evicts, c_evicts);
        chk("stat_full", st_full, c_full);
`else
        chk("stat_loads", st_loads, 0);
        chk("stat_evicts", st_evicts, 0);
        chk("stat_full", st_full, 0);
`endif
    endtask

    task automatic drive_random();
        rst         = ($urandom_range(0, 249) == 0);
        load_valid  = ($urandom_range(0, 2) == 0);
        evict_valid = ($urandom_range(0, 3) == 0);
        addr_load   = $urandom() & 32'hFFFF_FFFC;
        addr_evict  = $urandom() & 32'hFFFF_FFFC;
        evict_data  = $urandom();
        regd_in     = 5'($urandom_range(0, 31));
        way_in      = 1'($urandom_range(0, 1));
        mem_bus.mem_ready  = ($urandom_range(0, 2) == 0);
        mem_bus.mem_rvalid = (phase == PH_WAIT) ? ($urandom_range(0, 2) == 0)
                                                : ($urandom_range(0, 19) == 0);
        mem_bus.mem_rdata  = $urandom();
    endtask

    initial begin
        rst = 1'b1;
        load_valid = 0; evict_valid = 0; addr_load = 0; addr_evict = 0; evict_data = 0;
        regd_in = 0; way_in = 0;
        mem_bus.mem_ready = 0; mem_bus.mem_rvalid = 0; mem_bus.mem_rdata = 0;
        model_reset();
        @(posedge clk);
        model_step();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            check_outputs();
            drive_random();
            @(posedge clk);
            model_step();
        end
        @(negedge clk);
        check_outputs();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
